// File: rtl/dbg_probe_view.sv
// dbg_probe_view: switch-selected probe word viewer with live, freeze, history and trigger modes
module dbg_probe_view #(
   parameter int DATA_W     = 16,
   parameter int CHANNELS   = 64,
   parameter int SEL_W      = 8,
   parameter int HIST_DEPTH = 8,
   parameter int HIST_AW    = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CHANNELS*DATA_W-1:0]   probe_bus,
   input  logic [SEL_W-1:0]             sel,
   input  logic [1:0]                   mode,
   input  logic                         step,
   input  logic [DATA_W-1:0]            fallback,
   input  logic [DATA_W-1:0]            trig_val,
   input  logic [DATA_W-1:0]            trig_mask,
   output logic [DATA_W-1:0]            led_data,
   output logic [HIST_AW:0]             hist_count,
   output logic [HIST_AW-1:0]           hist_index,
   output logic                         trig_hit
);
   typedef enum logic [1:0] {LIVE, FREEZE, HIST, TRIG} mode_t;
   localparam int CW = $clog2(CHANNELS);
   localparam logic [HIST_AW:0] FULL = (HIST_AW+1)'(HIST_DEPTH);
   localparam logic [HIST_AW:0] ONE_C = (HIST_AW+1)'(1);
   localparam logic [HIST_AW-1:0] ONE_A = HIST_AW'(1);
   localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);
   logic [DATA_W-1:0] ch [CHANNELS];
   logic [DATA_W-1:0] hbuf [HIST_DEPTH];
   logic [DATA_W-1:0] cur, frz, cap, last_rec;
   logic [SEL_W-1:0] sel_q;
   logic [1:0] mode_q;
   logic [HIST_AW-1:0] wp, rd_ptr;
   logic [HIST_AW:0] idx_nx;
   logic step_q, armed, oor, step_rise, sel_chg, entering, do_rec, rearm, hit;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign ch[i] = probe_bus[i*DATA_W +: DATA_W];
   end

   // channel select, edge/change detection and the per-mode action conditions
   always_comb begin
      oor = {1'b0, sel} >= NCH;
      cur = oor ? fallback : ch[sel[CW-1:0]];
      step_rise = step & ~step_q;
      sel_chg = sel != sel_q;
      entering = mode != mode_q;
      do_rec = mode != HIST && !oor && !sel_chg && (hist_count == '0 || cur != last_rec);
      rearm = mode == TRIG && (entering || step_rise || sel_chg);
      hit = ((cur ^ trig_val) & trig_mask) == '0;
      rd_ptr = wp - hist_index - ONE_A;
      idx_nx = {1'b0, hist_index} + ONE_C;
   end

   // history storage; contents beyond hist_count are never shown so no reset is needed
   always_ff @(posedge clk) begin
      if (do_rec) hbuf[wp] <= cur;
   end

   // mode state, history bookkeeping, trigger capture and the registered display word
   always_ff @(posedge clk) begin
      if (!rst) begin
         led_data <= '0;
         hist_count <= '0;
         hist_index <= '0;
         trig_hit <= 1'b0;
         wp <= '0;
         armed <= 1'b0;
         frz <= '0;
         cap <= '0;
         last_rec <= '0;
         sel_q <= '0;
         mode_q <= '0;
         step_q <= 1'b0;
      end else begin
         sel_q <= sel;
         mode_q <= mode;
         step_q <= step;
         if (mode == FREEZE && (entering || step_rise || sel_chg)) frz <= cur;
         if (sel_chg) begin
            hist_count <= '0;
            wp <= '0;
         end else if (do_rec) begin
            last_rec <= cur;
            wp <= wp + ONE_A;
            if (hist_count != FULL) hist_count <= hist_count + ONE_C;
         end
         if (mode == HIST)
            hist_index <= entering ? '0 : !step_rise ? hist_index : idx_nx >= hist_count ? '0 : hist_index + ONE_A;
         if (mode != TRIG) begin
            armed <= 1'b0;
            trig_hit <= 1'b0;
         end else if (rearm) begin
            armed <= 1'b1;
            trig_hit <= 1'b0;
         end else if (armed && hit) begin
            cap <= cur;
            trig_hit <= 1'b1;
            armed <= 1'b0;
         end
         led_data <= mode == LIVE ? cur :
                     mode == FREEZE ? frz :
                     mode == HIST ? (hist_count == '0 ? '0 : hbuf[rd_ptr]) :
                     trig_hit ? cap : fallback;
      end
   end
endmodule
